pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall and bubble controller for the five-stage rv32i pipeline. It is the counterpart to the forwarding unit. Forwarding resolves RAW hazards by supplying data. This block resolves the hazards forwarding cannot cover:
- load-use hazards, by inserting one bubble into ID/EX;
- cache-miss latency, by freezing every pipeline register until all outstanding I-cache and D-cache requests have responded.

It generates the load enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps performance counters.

## Interface
- CNT_WIDTH, 32, width of each stall counter
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- control_word_ID  in  rv32i_control_word  decoded word in ID; uses .instr
- control_word_EX  in  rv32i_control_word  word in EX; uses .instr, .dest, .load_regfile
- icache_read  in  1  IF stage requests an instruction
- icache_resp  in  1  I-cache response strobe
- dcache_req  in  1  MEM stage read or write request
- dcache_resp  in  1  D-cache response strobe
- icache_read_gated  out  1  request actually driven to the I-cache
- dcache_req_gated  out  1  request actually driven to the D-cache
- instr_latch  out  1  IF/ID shadow register captures I-cache rdata
- load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  out  1 each  register enables
- bubble_ID_EX  out  1  ID/EX loads the all-zero NOP control word
- stall_loaduse_cnt  out  CNT_WIDTH  count of load-use bubble cycles
- stall_mem_cnt  out  CNT_WIDTH  count of memory-freeze cycles

## Operation

**State**
- Registered state: i_done and d_done sticky bits, FSM state {RUN, MEM_STALL}, and the two counters.

**Memory readiness**
- i_ok = !icache_read | i_done | icache_resp
- d_ok = !dcache_req | d_done | dcache_resp
- mem_ok = i_ok & d_ok

**Load-use hazard**
- hazard = (control_word_EX.instr[6:0] == op_load) & control_word_EX.load_regfile & (dest != 0) & (rs1_hit | rs2_hit).
- rs1_hit: ID opcode is not lui, auipc or jal, and ID instr[19:15] == dest.
- rs2_hit: ID opcode is reg, br or store, and ID instr[24:20] == dest.

**Priority 1: !mem_ok (freeze)**
- All load_* = 0 and bubble_ID_EX = 0.
- Next state MEM_STALL; stall_mem_cnt increments.
- An icache_resp sets i_done and a dcache_resp sets d_done at the clock edge.

**Priority 2: mem_ok & hazard (load-use bubble)**
- load_pc = 0 and load_IF_ID = 0.
- load_ID_EX = 1 with bubble_ID_EX = 1.
- load_EX_MEM = 1 and load_MEM_WB = 1.
- stall_loaduse_cnt increments.

**Priority 3: mem_ok & !hazard (advance)**
- All load_* = 1 and bubble_ID_EX = 0.

**Whenever mem_ok**
- Next state RUN; i_done and d_done clear at the clock edge.

**Request gating and capture**
- icache_read_gated = icache_read & !i_done.
- dcache_req_gated = dcache_req & !d_done. A completed access is never reissued while the other side is still waiting.
- instr_latch = icache_resp & !i_done. IF/ID selects the shadow register while i_done = 1.

**Counters**
- Free-running, wrap modulo 2^CNT_WIDTH, no saturation.

## Timing

**Reset**
- While rst = 0: state RUN, i_done = d_done = 0, both counters 0.
- While rst = 0, all outputs are forced to 0: load_*, bubble, gated requests, instr_latch.
- Outputs are valid from the first cycle after reset deassertion.

**Combinational paths**
- Enables, bubble, gating and instr_latch are combinational (Mealy) from inputs and registered state. There is zero-cycle latency from a resp strobe to release.

**Release timing**
- A resp arriving in the same cycle as the other side's already-done bit releases the pipeline that cycle; the sticky bit is not set.
- Both resps arriving in one cycle release immediately.

**Load-use**
- Lasts exactly one cycle. Next cycle EX holds the NOP, so hazard is 0 and the load's result is forwarded from MEM.

**Hazard during a freeze**
- Hazard is ignored while !mem_ok; the freeze dominates. The bubble is applied on the first mem_ok cycle.

**Reset mid-stall**
- Reset asserted during MEM_STALL clears the sticky bits immediately (async). Outstanding cache handshakes are abandoned.

## Structure
- Add to rv32i_types: the stall_state_t enum {RUN, MEM_STALL} and a NOP control-word constant used by ID/EX on bubble.
- Opcode constants (op_load, op_lui, …) come from rv32i_types.
- One natural sub-module: mem_wait_tracker, instantiated twice (I-side, D-side). Each holds a done bit and produces ok, gated request and capture strobe.

## Test plan
- **Load-use:** EX = lw x5,0(x1); ID = add x6,x5,x2; caches ready → one cycle with load_pc = 0, load_IF_ID = 0, bubble_ID_EX = 1; next cycle all enables 1; stall_loaduse_cnt = 1.
- **x0 and immediate-form exclusions:**
  - EX = lw x0; ID = add x6,x0,x2 → no bubble.
  - EX = lw x5; ID = lui x5 → no bubble.
  - EX = lw x5; ID = addi x7,x5,1 → bubble.
- **I-cache miss:** icache_read = 1, resp after 4 cycles → all enables 0 for 4 cycles, release in the resp cycle, stall_mem_cnt = 4.
- **Split responses:** both requests at cycle 0; icache_resp at cycle 2, dcache_resp at cycle 6 →
  - instr_latch pulses at cycle 2;
  - icache_read_gated = 0 for cycles 3–6;
  - release at cycle 6, then i_done = 0.
- **Hazard during freeze:** load-use hazard plus D-cache miss of 3 cycles → freeze 3 cycles, bubble on cycle 3, counters mem = 3, loaduse = 1.
- **Async reset mid-stall:** drop rst while d_done = 1 → outputs 0 immediately, counters 0; after rst = 1, state RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared rv32i types for the pipeline stall controller: the control word,
// opcode constants, the stall FSM state and the NOP control word.
package pipeline_stall_ctrl_pkg;

    // Opcode field values (instr[6:0])
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;
    localparam logic [6:0] op_csr   = 7'b1110011;

    // Decoded control word carried down the pipeline
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        load_regfile;
    } rv32i_control_word;

    // Stall controller state
    typedef enum logic {
        RUN       = 1'b0,
        MEM_STALL = 1'b1
    } stall_state_t;

    // Control word loaded into ID/EX when a bubble is inserted
    localparam rv32i_control_word NOP_CTRL_WORD = '0;

    // True when the instruction reads rs1 (everything except U-type and jal)
    function automatic logic reads_rs1(input logic [6:0] opcode);
        return !(opcode == op_lui || opcode == op_auipc || opcode == op_jal);
    endfunction

    // True when the instruction reads rs2 (R-type, branches, stores)
    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == op_reg || opcode == op_br || opcode == op_store);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mem_wait_tracker.sv
// Tracks one outstanding cache request: remembers that its response has
// already arrived while the other cache is still busy, suppresses re-issue
// of the completed request and flags when the response data must be captured.
module pipeline_stall_ctrl_mem_wait_tracker (
    input  logic clk,
    input  logic rst,          // asynchronous, active-low
    input  logic req_i,        // stage wants a cache access this cycle
    input  logic resp_i,       // cache response strobe
    input  logic release_i,    // whole pipeline advances this cycle
    output logic ok_o,         // this side does not hold the pipeline
    output logic req_gated_o,  // request actually presented to the cache
    output logic capture_o     // shadow register captures the response
);

    logic done_q;
    logic done_d;

    // This side is satisfied if idle, already answered, or answered now
    assign ok_o        = !req_i | done_q | resp_i;
    // Do not re-issue a completed access; nothing is driven during reset
    assign req_gated_o = rst & req_i & !done_q;
    assign capture_o   = rst & resp_i & !done_q;

    // Sticky done bit: set by a response, cleared when the pipeline moves
    always_comb begin
        done_d = done_q;
        if (release_i) begin
            done_d = 1'b0;
        end else if (resp_i) begin
            done_d = 1'b1;
        end
    end

    // Done bit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble controller for the five-stage rv32i pipeline.
// Freezes every pipeline register while any cache access is outstanding and
// inserts a single ID/EX bubble on a load-use hazard. Enables are Mealy
// outputs so a cache response releases the pipeline in the same cycle.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active-low
    input  rv32i_control_word    control_word_ID,
    input  rv32i_control_word    control_word_EX,
    input  logic                 icache_read,
    input  logic                 icache_resp,
    input  logic                 dcache_req,
    input  logic                 dcache_resp,
    output logic                 icache_read_gated,
    output logic                 dcache_req_gated,
    output logic                 instr_latch,
    output logic                 load_pc,
    output logic                 load_IF_ID,
    output logic                 load_ID_EX,
    output logic                 load_EX_MEM,
    output logic                 load_MEM_WB,
    output logic                 bubble_ID_EX,
    output logic [CNT_WIDTH-1:0] stall_loaduse_cnt,
    output logic [CNT_WIDTH-1:0] stall_mem_cnt
);

    stall_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_mem_cnt_q, stall_mem_cnt_d;
    logic [CNT_WIDTH-1:0] stall_lu_cnt_q, stall_lu_cnt_d;

    logic i_ok, d_ok, mem_ok;
    logic hazard;
    logic rs1_hit, rs2_hit;
    logic [6:0] id_op;
    logic [6:0] ex_op;
    logic [4:0] ex_dest;

    // I-side and D-side trackers release together on the pipeline advance
    pipeline_stall_ctrl_mem_wait_tracker u_itrack (
        .clk         (clk),
        .rst         (rst),
        .req_i       (icache_read),
        .resp_i      (icache_resp),
        .release_i   (mem_ok),
        .ok_o        (i_ok),
        .req_gated_o (icache_read_gated),
        .capture_o   (instr_latch)
    );

    pipeline_stall_ctrl_mem_wait_tracker u_dtrack (
        .clk         (clk),
        .rst         (rst),
        .req_i       (dcache_req),
        .resp_i      (dcache_resp),
        .release_i   (mem_ok),
        .ok_o        (d_ok),
        .req_gated_o (dcache_req_gated),
        .capture_o   ()
    );

    assign mem_ok = i_ok & d_ok;

    assign id_op   = control_word_ID.instr[6:0];
    assign ex_op   = control_word_EX.instr[6:0];
    assign ex_dest = control_word_EX.dest;

    // Load-use hazard: a register-writing load in EX feeds a source read in ID
    always_comb begin
        rs1_hit = reads_rs1(id_op) && (control_word_ID.instr[19:15] == ex_dest);
        rs2_hit = reads_rs2(id_op) && (control_word_ID.instr[24:20] == ex_dest);
        hazard  = (ex_op == op_load) && control_word_EX.load_regfile &&
                  (ex_dest != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Priority: memory freeze, then load-use bubble, then normal advance
    always_comb begin
        state_d         = state_q;
        stall_mem_cnt_d = stall_mem_cnt_q;
        stall_lu_cnt_d  = stall_lu_cnt_q;
        load_pc         = 1'b0;
        load_IF_ID      = 1'b0;
        load_ID_EX      = 1'b0;
        load_EX_MEM     = 1'b0;
        load_MEM_WB     = 1'b0;
        bubble_ID_EX    = 1'b0;
        if (!mem_ok) begin
            state_d         = MEM_STALL;
            stall_mem_cnt_d = stall_mem_cnt_q + CNT_WIDTH'(1);
        end else begin
            state_d     = RUN;
            load_ID_EX  = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
            if (hazard) begin
                bubble_ID_EX   = 1'b1;
                stall_lu_cnt_d = stall_lu_cnt_q + CNT_WIDTH'(1);
            end else begin
                load_pc    = 1'b1;
                load_IF_ID = 1'b1;
            end
        end
        // Everything is held low while reset is asserted
        if (!rst) begin
            load_pc      = 1'b0;
            load_IF_ID   = 1'b0;
            load_ID_EX   = 1'b0;
            load_EX_MEM  = 1'b0;
            load_MEM_WB  = 1'b0;
            bubble_ID_EX = 1'b0;
        end
    end

    // State and performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= RUN;
            stall_mem_cnt_q <= '0;
            stall_lu_cnt_q  <= '0;
        end else begin
            state_q         <= state_d;
            stall_mem_cnt_q <= stall_mem_cnt_d;
            stall_lu_cnt_q  <= stall_lu_cnt_d;
        end
    end

    assign stall_mem_cnt     = stall_mem_cnt_q;
    assign stall_loaduse_cnt = stall_lu_cnt_q;

    // The state register is kept for debug visibility only; outputs derive
    // from the done bits directly. Fields not needed for hazard detection
    // are collected here.
    logic unused_bits;
    assign unused_bits = ^{state_q, control_word_ID.instr[31:25],
                           control_word_ID.instr[14:7], control_word_ID.dest,
                           control_word_ID.load_regfile,
                           control_word_EX.instr[31:7]};

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a vector table for the
// single-cycle decisions plus hand sequences for multi-cycle stalls.
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    rv32i_control_word control_word_ID, control_word_EX;
    logic icache_read, icache_resp, dcache_req, dcache_resp;
    logic icache_read_gated, dcache_req_gated, instr_latch;
    logic load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB;
    logic bubble_ID_EX;
    logic [CW-1:0] stall_loaduse_cnt, stall_mem_cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .control_word_ID   (control_word_ID),
        .control_word_EX   (control_word_EX),
        .icache_read       (icache_read),
        .icache_resp       (icache_resp),
        .dcache_req        (dcache_req),
        .dcache_resp       (dcache_resp),
        .icache_read_gated (icache_read_gated),
        .dcache_req_gated  (dcache_req_gated),
        .instr_latch       (instr_latch),
        .load_pc           (load_pc),
        .load_IF_ID        (load_IF_ID),
        .load_ID_EX        (load_ID_EX),
        .load_EX_MEM       (load_EX_MEM),
        .load_MEM_WB       (load_MEM_WB),
        .bubble_ID_EX      (bubble_ID_EX),
        .stall_loaduse_cnt (stall_loaduse_cnt),
        .stall_mem_cnt     (stall_mem_cnt)
    );

    typedef struct {
        string             name;
        logic              ir, irs, dr, drs;
        rv32i_control_word ex, id;
        logic [4:0]        loads;   // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}
        logic              bub, ig, dg, il;
    } vec_t;

    localparam logic [4:0] L_ALL = 5'b11111;
    localparam logic [4:0] L_BUB = 5'b00111;
    localparam logic [4:0] L_NO  = 5'b00000;

    vec_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_mem = 0;
    int exp_lu  = 0;

    function automatic rv32i_control_word cw(input logic [31:0] instr,
                                             input logic [4:0] dest,
                                             input logic lr);
        rv32i_control_word c;
        c.instr = instr;
        c.dest = dest;
        c.load_regfile = lr;
        return c;
    endfunction

    function automatic vec_t mk(input string n, input logic ir, irs, dr, drs,
                                input rv32i_control_word ex, id,
                                input logic [4:0] ld, input logic b, ig, dg, il);
        vec_t v;
        v.name = n; v.ir = ir; v.irs = irs; v.dr = dr; v.drs = drs;
        v.ex = ex; v.id = id; v.loads = ld; v.bub = b; v.ig = ig; v.dg = dg; v.il = il;
        return v;
    endfunction

    // Instruction encodings
    rv32i_control_word LW5, LW0, LW5_NOLR, ADDX5, NOP;
    rv32i_control_word ADD_X5, ADD_X0, LUI5, ADDI_X5, SW_X5, ADDI_IMM5, JAL5, JALR_X5;

    task automatic drive(input vec_t v);
        icache_read = v.ir; icache_resp = v.irs;
        dcache_req = v.dr; dcache_resp = v.drs;
        control_word_EX = v.ex; control_word_ID = v.id;
        exp_q.push_back(v);
    endtask

    task automatic compare_out();
        vec_t e;
        logic [8:0] act, req;
        e = exp_q.pop_front();
        act = {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
               bubble_ID_EX, icache_read_gated, dcache_req_gated, instr_latch};
        req = {e.loads, e.bub, e.ig, e.dg, e.il};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: loads/bub/ig/dg/il got %b want %b", e.name, act, req);
        end else begin
            $display("vec %s: loads/bub/ig/dg/il = %b", e.name, act);
        end
        if (e.loads == L_NO) exp_mem++;
        if (e.bub) exp_lu++;
    endtask

    // Drive at posedge+1, compare mid-cycle, return at next posedge+1
    task automatic apply(input vec_t v);
        drive(v);
        #2;
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string n);
        checks++;
        if (stall_mem_cnt !== CW'(exp_mem) || stall_loaduse_cnt !== CW'(exp_lu)) begin
            errors++;
            $display("FAIL %s: mem_cnt=%0d loaduse_cnt=%0d want mem=%0d loaduse=%0d",
                     n, stall_mem_cnt, stall_loaduse_cnt, exp_mem, exp_lu);
        end else begin
            $display("cnt %s: mem=%0d loaduse=%0d", n, stall_mem_cnt, stall_loaduse_cnt);
        end
    endtask

    task automatic check_all_zero(input string n);
        logic [8:0] act;
        act = {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
               bubble_ID_EX, icache_read_gated, dcache_req_gated, instr_latch};
        checks++;
        if (act !== 9'd0 || stall_mem_cnt !== '0 || stall_loaduse_cnt !== '0) begin
            errors++;
            $display("FAIL %s: outputs %b cnt %0d/%0d want all zero",
                     n, act, stall_mem_cnt, stall_loaduse_cnt);
        end else begin
            $display("rst %s: outputs zero", n);
        end
    endtask

    // Reset with active inputs so unmasked outputs would show up
    task automatic do_reset();
        rst = 1'b0;
        icache_read = 1'b1; icache_resp = 1'b1; dcache_req = 1'b1; dcache_resp = 1'b1;
        control_word_EX = NOP; control_word_ID = NOP;
        #2;
        check_all_zero("reset");
        exp_mem = 0;
        exp_lu = 0;
        @(posedge clk);
        #1;
        icache_read = 1'b0; icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
        rst = 1'b1;
    endtask

    vec_t tbl[14];

    initial begin
        LW5       = cw(32'h0000A283, 5'd5, 1'b1);
        LW0       = cw(32'h0000A003, 5'd0, 1'b1);
        LW5_NOLR  = cw(32'h0000A283, 5'd5, 1'b0);
        ADDX5     = cw(32'h002082B3, 5'd5, 1'b1);
        NOP       = NOP_CTRL_WORD;
        ADD_X5    = cw(32'h00228333, 5'd6, 1'b1);
        ADD_X0    = cw(32'h00200333, 5'd6, 1'b1);
        LUI5      = cw(32'h000282B7, 5'd5, 1'b1);
        ADDI_X5   = cw(32'h00128393, 5'd7, 1'b1);
        SW_X5     = cw(32'h0050A023, 5'd0, 1'b0);
        ADDI_IMM5 = cw(32'h00508393, 5'd7, 1'b1);
        JAL5      = cw(32'h000280EF, 5'd1, 1'b1);
        JALR_X5   = cw(32'h000280E7, 5'd1, 1'b1);

        tbl[0]  = mk("lu_add",    0,0,0,0, LW5,      ADD_X5,    L_BUB, 1,0,0,0);
        tbl[1]  = mk("nop_adv",   0,0,0,0, NOP,      ADD_X5,    L_ALL, 0,0,0,0);
        tbl[2]  = mk("lw_x0",     0,0,0,0, LW0,      ADD_X0,    L_ALL, 0,0,0,0);
        tbl[3]  = mk("lui",       0,0,0,0, LW5,      LUI5,      L_ALL, 0,0,0,0);
        tbl[4]  = mk("addi_rs1",  0,0,0,0, LW5,      ADDI_X5,   L_BUB, 1,0,0,0);
        tbl[5]  = mk("sw_rs2",    0,0,0,0, LW5,      SW_X5,     L_BUB, 1,0,0,0);
        tbl[6]  = mk("addi_imm",  0,0,0,0, LW5,      ADDI_IMM5, L_ALL, 0,0,0,0);
        tbl[7]  = mk("jal",       0,0,0,0, LW5,      JAL5,      L_ALL, 0,0,0,0);
        tbl[8]  = mk("ex_alu",    0,0,0,0, ADDX5,    ADD_X5,    L_ALL, 0,0,0,0);
        tbl[9]  = mk("no_lr",     0,0,0,0, LW5_NOLR, ADD_X5,    L_ALL, 0,0,0,0);
        tbl[10] = mk("i_hit",     1,1,0,0, NOP,      NOP,       L_ALL, 0,1,0,1);
        tbl[11] = mk("d_miss_lu", 0,0,1,0, LW5,      ADD_X5,    L_NO,  0,0,1,0);
        tbl[12] = mk("both_hit",  1,1,1,1, LW5,      ADD_X5,    L_BUB, 1,1,1,1);
        tbl[13] = mk("jalr_rs1",  0,0,0,0, LW5,      JALR_X5,   L_BUB, 1,0,0,0);

        @(posedge clk);
        #1;
        do_reset();

        // Single-cycle decision table
        for (int i = 0; i < 14; i++) apply(tbl[i]);
        check_cnt("table");

        // Load-use: one bubble, then advance
        do_reset();
        apply(mk("lu0", 0,0,0,0, LW5, ADD_X5, L_BUB, 1,0,0,0));
        apply(mk("lu1", 0,0,0,0, NOP, ADD_X5, L_ALL, 0,0,0,0));
        check_cnt("loaduse");

        // I-cache miss: 4 frozen cycles, release on the response
        do_reset();
        for (int c = 0; c < 4; c++) apply(mk("imiss", 1,0,0,0, NOP, NOP, L_NO, 0,1,0,0));
        apply(mk("irel", 1,1,0,0, NOP, NOP, L_ALL, 0,1,0,1));
        check_cnt("imiss");

        // Split responses: I at cycle 2, D at cycle 6
        do_reset();
        for (int c = 0; c < 2; c++) apply(mk("split_wait", 1,0,1,0, NOP, NOP, L_NO, 0,1,1,0));
        apply(mk("split_iresp", 1,1,1,0, NOP, NOP, L_NO, 0,1,1,1));
        for (int c = 3; c < 6; c++) apply(mk("split_idone", 1,0,1,0, NOP, NOP, L_NO, 0,0,1,0));
        apply(mk("split_drel", 1,0,1,1, NOP, NOP, L_ALL, 0,0,1,0));
        apply(mk("split_after", 1,1,0,0, NOP, NOP, L_ALL, 0,1,0,1));
        check_cnt("split");

        // Hazard during a D-cache freeze: bubble only on release
        do_reset();
        for (int c = 0; c < 3; c++) apply(mk("hz_freeze", 0,0,1,0, LW5, ADD_X5, L_NO, 0,0,1,0));
        apply(mk("hz_release", 0,0,1,1, LW5, ADD_X5, L_BUB, 1,0,1,0));
        check_cnt("hz_freeze");

        // Async reset while d_done is set
        do_reset();
        apply(mk("ar_dresp", 1,0,1,1, NOP, NOP, L_NO, 0,1,1,0));
        apply(mk("ar_ddone", 1,0,1,0, NOP, NOP, L_NO, 0,1,0,0));
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_mem = 0;
        exp_lu = 0;
        @(posedge clk);
        #1;
        icache_read = 1'b0; icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.state_q !== RUN) begin
            errors++;
            $display("FAIL state_after_rst: state=%0d want %0d", dut.state_q, RUN);
        end else begin
            $display("state after reset: RUN");
        end
        apply(mk("ar_dreq", 0,0,1,0, NOP, NOP, L_NO, 0,0,1,0));
        check_cnt("async_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
